// File: rtl/alu_pkg.sv
// alu_pkg: ARM data-processing opcodes, condition codes, NZCV bit indices and condition evaluation
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ARM data-processing ALU producing result, NZCV candidates and write enable
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] rn,
  input  logic [DATA_W-1:0] op,
  input  logic              shifter_carry,
  input  logic              c_in,
  input  logic              v_in,
  output logic [DATA_W-1:0] res,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v,
  output logic              wr_en
);
  logic [DATA_W-1:0] a, b, lres;
  logic [DATA_W:0]   sum;
  logic              ci, arith;
  // every arithmetic op is a + b + ci, with reversal/inversion folded into a and b
  always_comb begin
    a = rn;
    b = op;
    ci = 1'b0;
    arith = 1'b1;
    case (opcode)
      OP_SUB, OP_CMP: begin b = ~op; ci = 1'b1; end
      OP_RSB: begin a = op; b = ~rn; ci = 1'b1; end
      OP_ADC: ci = c_in;
      OP_SBC: begin b = ~op; ci = c_in; end
      OP_RSC: begin a = op; b = ~rn; ci = c_in; end
      OP_ADD, OP_CMN: ;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
  end
  always_comb begin
    case (opcode)
      OP_AND, OP_TST: lres = rn & op;
      OP_EOR, OP_TEQ: lres = rn ^ op;
      OP_ORR: lres = rn | op;
      OP_MOV: lres = op;
      OP_BIC: lres = rn & ~op;
      default: lres = ~op;
    endcase
  end
  assign res   = arith ? sum[DATA_W-1:0] : lres;
  assign n     = res[DATA_W-1];
  assign z     = res == '0;
  assign c     = arith ? sum[DATA_W] : shifter_carry;
  assign v     = arith ? (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]) : v_in;
  assign wr_en = opcode[3:2] != 2'b10;
endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute ALU with NZCV register and one-entry EX/MEM buffer; ALU_COND_CHECK_EN enables condition gating
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic                  s_bit,
  input  logic [3:0]            cond,
  input  logic [DATA_W-1:0]     rn,
  input  logic [DATA_W-1:0]     shifter_out,
  input  logic                  shifter_carry_out,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  c_flag,
  output logic [3:0]            flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     result,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_wr_en
);
  logic [3:0]            flags_q, flags_d;
  logic                  valid_q, valid_d, wr_q, wr_d;
  logic [DATA_W-1:0]     result_q, result_d, res;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  n, z, c, v, core_wr, accept, cond_pass, upd;
  alu_core #(.DATA_W(DATA_W)) u_core (
    .opcode       (opcode),
    .rn           (rn),
    .op           (shifter_out),
    .shifter_carry(shifter_carry_out),
    .c_in         (flags_q[FLAG_C]),
    .v_in         (flags_q[FLAG_V]),
    .res          (res),
    .n            (n),
    .z            (z),
    .c            (c),
    .v            (v),
    .wr_en        (core_wr)
  );
`ifdef ALU_COND_CHECK_EN
  assign cond_pass = cond_ok(cond, flags_q);
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_pass = 1'b1;
`endif
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // compare/test opcodes always write flags; a failed condition never does
  assign upd      = accept && cond_pass && (s_bit || !core_wr);
  always_comb begin
    flags_d  = upd ? {n, z, c, v} : flags_q;
    valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    result_d = accept ? (cond_pass ? res : '0) : result_q;
    rd_d     = accept ? rd_addr : rd_q;
    wr_d     = accept ? (cond_pass && core_wr) : wr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end
  assign flags       = flags_q;
  assign c_flag      = flags_q[FLAG_C];
  assign out_valid   = valid_q;
  assign result      = result_q;
  assign out_rd_addr = rd_q;
  assign out_wr_en   = wr_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vector table plus backpressure and async-reset sequences for ex_alu_stage
module tb_ex_alu_stage;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic        s_bit = 1'b0;
  logic [3:0]  cond = COND_AL;
  logic [31:0] rn = '0;
  logic [31:0] shifter_out = '0;
  logic        shifter_carry_out = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        c_flag;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  out_rd_addr;
  logic        out_wr_en;
  int          n_cmp = 0;
  int          n_err = 0;

  ex_alu_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .s_bit            (s_bit),
    .cond             (cond),
    .rn               (rn),
    .shifter_out      (shifter_out),
    .shifter_carry_out(shifter_carry_out),
    .rd_addr          (rd_addr),
    .c_flag           (c_flag),
    .flags            (flags),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .out_rd_addr      (out_rd_addr),
    .out_wr_en        (out_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        sc;
    logic [31:0] res;
    logic        wr;
    logic [3:0]  fl;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic [3:0] rd);
    in_valid = 1'b1;
    opcode = o;
    s_bit = s;
    rn = a;
    shifter_out = b;
    shifter_carry_out = sc;
    rd_addr = rd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         1'b1, 4'b0110};
    vt[1]  = '{OP_ADC, 1'b1, 32'h5,         32'h3,         1'b0, 32'h9,         1'b1, 4'b0000};
    vt[2]  = '{OP_CMP, 1'b1, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b0, 4'b0011};
    vt[3]  = '{OP_MOV, 1'b1, 32'h1234,      32'h0,         1'b1, 32'h0,         1'b1, 4'b0111};
    vt[4]  = '{OP_SUB, 1'b1, 32'h3,         32'h5,         1'b0, 32'hFFFF_FFFE, 1'b1, 4'b1000};
    vt[5]  = '{OP_RSB, 1'b1, 32'h3,         32'h5,         1'b0, 32'h2,         1'b1, 4'b0010};
    vt[6]  = '{OP_SBC, 1'b1, 32'hA,         32'h3,         1'b0, 32'h7,         1'b1, 4'b0010};
    vt[7]  = '{OP_RSC, 1'b1, 32'hA,         32'h3,         1'b0, 32'hFFFF_FFF9, 1'b1, 4'b1000};
    vt[8]  = '{OP_SBC, 1'b1, 32'hA,         32'h3,         1'b0, 32'h6,         1'b1, 4'b0010};
    vt[9]  = '{OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b1, 4'b1001};
    vt[10] = '{OP_AND, 1'b0, 32'hF0F0,      32'hFF00,      1'b0, 32'hF000,      1'b1, 4'b1001};
    vt[11] = '{OP_EOR, 1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_FFFF, 1'b1, 4'b0001};
    vt[12] = '{OP_ORR, 1'b0, 32'h0F,        32'hF0,        1'b0, 32'hFF,        1'b1, 4'b0001};
    vt[13] = '{OP_BIC, 1'b0, 32'hFF,        32'h0F,        1'b0, 32'hF0,        1'b1, 4'b0001};
    vt[14] = '{OP_MVN, 1'b1, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1011};
    vt[15] = '{OP_TST, 1'b0, 32'hF0,        32'h0F,        1'b0, 32'h0,         1'b0, 4'b0101};
    vt[16] = '{OP_TEQ, 1'b0, 32'h5,         32'h5,         1'b1, 32'h0,         1'b0, 4'b0111};
    vt[17] = '{OP_CMN, 1'b0, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         1'b0, 4'b0110};
    vt[18] = '{OP_ADD, 1'b0, 32'h1,         32'h2,         1'b0, 32'h3,         1'b1, 4'b0110};
    vt[19] = '{OP_ADC, 1'b0, 32'h1,         32'h2,         1'b0, 32'h4,         1'b1, 4'b0110};

    #3;
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset out_wr_en", {31'b0, out_wr_en}, 32'h0);
    chk("reset out_rd_addr", {28'b0, out_rd_addr}, 32'h0);
    chk("reset flags", {28'b0, flags}, 32'h0);
    chk("reset in_ready", {31'b0, in_ready}, 32'h1);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].opc, vt[i].s, vt[i].a, vt[i].b, vt[i].sc, 4'(i));
      step();
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d result", i), result, vt[i].res);
      chk($sformatf("v%0d out_wr_en", i), {31'b0, out_wr_en}, {31'b0, vt[i].wr});
      chk($sformatf("v%0d out_rd_addr", i), {28'b0, out_rd_addr}, 32'(i[3:0]));
      chk($sformatf("v%0d flags", i), {28'b0, flags}, {28'b0, vt[i].fl});
      chk($sformatf("v%0d c_flag", i), {31'b0, c_flag}, {31'b0, vt[i].fl[1]});
    end

    in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'b0, out_valid}, 32'h0);

    out_ready = 1'b0;
    drive(OP_ADD, 1'b1, 32'h1, 32'h1, 1'b0, 4'd3);
    step();
    chk("bp X valid", {31'b0, out_valid}, 32'h1);
    chk("bp X result", result, 32'h2);
    chk("bp X flags", {28'b0, flags}, 32'h0);
    drive(OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd4);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold%0d in_ready", k), {31'b0, in_ready}, 32'h0);
      step();
      chk($sformatf("bp hold%0d result", k), result, 32'h2);
      chk($sformatf("bp hold%0d rd", k), {28'b0, out_rd_addr}, 32'h3);
      chk($sformatf("bp hold%0d flags", k), {28'b0, flags}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp Y valid", {31'b0, out_valid}, 32'h1);
    chk("bp Y result", result, 32'h0);
    chk("bp Y rd", {28'b0, out_rd_addr}, 32'h4);
    chk("bp Y flags", {28'b0, flags}, 32'h6);
    drive(OP_MOV, 1'b0, 32'h0, 32'h55, 1'b0, 4'd5);
    step();
    chk("bp Z result", result, 32'h55);
    chk("bp Z rd", {28'b0, out_rd_addr}, 32'h5);
    chk("bp Z flags", {28'b0, flags}, 32'h6);
    in_valid = 1'b0;
    step();
    chk("bp drain valid", {31'b0, out_valid}, 32'h0);

    out_ready = 1'b0;
    drive(OP_MOV, 1'b1, 32'h0, 32'h1234, 1'b1, 4'd7);
    step();
    in_valid = 1'b0;
    chk("ar pre valid", {31'b0, out_valid}, 32'h1);
    chk("ar pre flags", {28'b0, flags}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar out_valid", {31'b0, out_valid}, 32'h0);
    chk("ar flags", {28'b0, flags}, 32'h0);
    chk("ar c_flag", {31'b0, c_flag}, 32'h0);
    chk("ar result", result, 32'h0);
    chk("ar out_wr_en", {31'b0, out_wr_en}, 32'h0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post reset idle", {31'b0, out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage ALU, directly downstream of the shifter. Consumes the shifter operand and shifter carry-out.
- Performs the 16 ARM data-processing operations on Rn and the shifter operand.
- Holds the NZCV condition-flag register and drives the C flag back as the shifter's C_in.
- Result is registered into a one-entry EX/MEM output buffer with a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported)
- REG_ADDR_W, 4, destination register address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operation present
- in_ready  output  1  stage can accept this cycle
- opcode  input  4  ARM DP opcode: AND=0, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN=15
- s_bit  input  1  update flags
- cond  input  4  ARM condition field (used only with the optional feature)
- rn  input  32  first operand
- shifter_out  input  32  shifter operand
- shifter_carry_out  input  1  shifter carry
- rd_addr  input  4  destination register
- c_flag  output  1  current C flag, wired to shifter C_in
- flags  output  4  {N,Z,C,V} register
- out_valid  output  1  result buffer full
- out_ready  input  1  downstream accepts
- result  output  32  registered ALU result
- out_rd_addr  output  4  registered destination
- out_wr_en  output  1  1 unless the opcode is TST, TEQ, CMP or CMN

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, result=0, out_rd_addr=0, out_wr_en=0, flags=4'b0000.
  - An operation held in the buffer is discarded, and no flag update occurs.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready. Inputs must be held stable while in_valid=1 and in_ready=0.
  - Latency is 1 cycle: an operation accepted at edge k is presented with out_valid=1 after edge k.
  - Buffer is held while out_valid && !out_ready.
  - Simultaneous drain and accept yields back-to-back throughput of 1 op/cycle.
  - Drain without accept clears out_valid.
- Arithmetic:
  - Uses a 33-bit internal sum.
  - SUB/CMP compute rn + ~op + 1, RSB computes op + ~rn + 1, SBC computes rn + ~op + C, RSC computes op + ~rn + C, ADC computes rn + op + C.
  - Arithmetic carry is bit 32 of the sum; for subtraction this is NOT borrow.
  - V is set when both operands (after inversion) have equal sign and the sum sign differs.
- Flag update:
  - Happens only at an accept edge with s_bit=1. Test/compare opcodes update flags regardless of s_bit.
  - N = res[31]; Z = (res == 0).
  - Arithmetic ops set C = carry and V = overflow.
  - Logical ops set C = shifter_carry_out and leave V unchanged.
- Forwarding:
  - Flags written at edge k are visible on flags/c_flag after edge k.
  - The next accepted op therefore sees the updated C. No internal bypass.
- Wrap-around: results wrap modulo 2^32.

Optional Feature:
- Macro: ALU_COND_CHECK_EN.
- Defined:
  - cond is evaluated against the current flags (EQ..AL, with NV treated as never).
  - A failing op is still accepted and propagated with out_wr_en=0, with no flag update and result=0.
- Undefined: cond is ignored and all ops execute.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_AND..OP_MVN)
  - condition localparams (COND_EQ..COND_NV)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- One sub-module, alu_core: purely combinational opcode → {res, n, z, c, v, wr_en}.
- ex_alu_stage wraps alu_core with the flag register, output buffer and handshake.

Test Plan:
- Reset sequence, then ADD rn=0xFFFFFFFF, op=1, S=1 → result 0x00000000 after 1 cycle, flags NZCV=0110, c_flag=1.
- ADC rn=5, op=3, following the previous op (C=1) → result 9, out_wr_en=1.
- CMP rn=0x80000000, op=1 → out_wr_en=0, flags=0011 (C=1 no borrow, V=1).
- MOV S=1, shifter_out=0, shifter_carry_out=1 with prior V=1 → flags=0111 (V preserved).
- out_ready=0 for 3 cycles with in_valid=1:
  - the first op is held in the buffer,
  - in_ready=0 while the buffer is full,
  - no second flag update occurs,
  - after out_ready rises, ops emerge in order at 1/cycle.
- rst_n asserted while out_valid=1 → out_valid=0 and flags=0 immediately (asynchronous).
- With ALU_COND_CHECK_EN: EQ-conditioned ADD while Z=0 → out_wr_en=0 and flags unchanged.
